// File: rtl/bin_clock_core.sv
// Binary time-of-day counter (12h/24h) with synchronised step buttons,
// a 1 Hz prescaler tick and a sticky alarm flag.
module bin_clock_core #(
    parameter int CLK_HZ   = 100,
    parameter bit MODE_24H = 1'b0
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       time_set_i,
    input  logic       id_switch_i,
    input  logic       seconds_id_i,
    input  logic       minute_id_i,
    input  logic       hour_id_i,
    input  logic       alarm_en_i,
    input  logic [4:0] alarm_hour_i,
    input  logic [5:0] alarm_minute_i,
    input  logic       alarm_pm_i,
    input  logic       alarm_ack_i,
    output logic [4:0] hour_o,
    output logic [5:0] minute_o,
    output logic [5:0] second_o,
    output logic       pm_o,
    output logic       tick_o,
    output logic       alarm_o
);
    localparam int            PW         = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [4:0]    HOUR_RST   = MODE_24H ? 5'd0 : 5'd12;

    logic          set_s1_q, set_s1_d, set_s2_q, set_s2_d;
    logic [2:0]    btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_prev_q, btn_prev_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          alarm_q, alarm_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic          pm_q, pm_d;
    logic [2:0]    step;
    logic          alarm_hit;

    function automatic logic [5:0] wrap59(input logic [5:0] v, input logic up);
        if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
    endfunction

    // 12h hours walk a 24-position ring; pm flips only across the 11<->12 boundary.
    function automatic logic [5:0] hour_step(input logic [4:0] h, input logic pm,
                                             input logic up);
        logic [4:0] nh;
        logic       npm;
        nh  = h;
        npm = pm;
        if (MODE_24H) begin
            if (up) nh = (h >= 5'd23) ? 5'd0 : h + 5'd1;
            else    nh = (h == 5'd0 || h > 5'd23) ? 5'd23 : h - 5'd1;
        end else if (up) begin
            if (h == 5'd11) begin
                nh  = 5'd12;
                npm = ~pm;
            end else if (h >= 5'd12 || h == 5'd0) begin
                nh = 5'd1;
            end else begin
                nh = h + 5'd1;
            end
        end else begin
            if (h == 5'd12) begin
                nh  = 5'd11;
                npm = ~pm;
            end else if (h <= 5'd1 || h > 5'd12) begin
                nh = 5'd12;
            end else begin
                nh = h - 5'd1;
            end
        end
        return {npm, nh};
    endfunction

    always_comb begin
        set_s1_d   = time_set_i;
        set_s2_d   = set_s1_q;
        btn_s1_d   = {hour_id_i, minute_id_i, seconds_id_i};
        btn_s2_d   = btn_s1_q;
        btn_prev_d = btn_s2_q;
        step       = btn_s2_q & ~btn_prev_q;

        presc_d = presc_q;
        tick_d  = 1'b0;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        pm_d    = pm_q;

        if (set_s2_q) begin
            presc_d = '0;
            if (step[0])      sec_d          = wrap59(sec_q, id_switch_i);
            else if (step[1]) min_d          = wrap59(min_q, id_switch_i);
            else if (step[2]) {pm_d, hour_d} = hour_step(hour_q, pm_q, id_switch_i);
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            sec_d   = wrap59(sec_q, 1'b1);
            if (sec_q == 6'd59) begin
                min_d = wrap59(min_q, 1'b1);
                if (min_q == 6'd59) {pm_d, hour_d} = hour_step(hour_q, pm_q, 1'b1);
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end

        // Match against the time being loaded on this edge, only on a run tick.
        alarm_hit = tick_d && alarm_en_i && (hour_d == alarm_hour_i) &&
                    (min_d == alarm_minute_i) && (sec_d == 6'd0) &&
                    (MODE_24H || (pm_d == alarm_pm_i));
        alarm_d = alarm_q;
        if (alarm_ack_i || !alarm_en_i) alarm_d = 1'b0;
        if (alarm_hit)                  alarm_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            set_s1_q   <= 1'b0;
            set_s2_q   <= 1'b0;
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            btn_prev_q <= '0;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            alarm_q    <= 1'b0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= HOUR_RST;
            pm_q       <= 1'b0;
        end else begin
            set_s1_q   <= set_s1_d;
            set_s2_q   <= set_s2_d;
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            btn_prev_q <= btn_prev_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            alarm_q    <= alarm_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            pm_q       <= pm_d;
        end
    end

    assign hour_o   = hour_q;
    assign minute_o = min_q;
    assign second_o = sec_q;
    assign pm_o     = MODE_24H ? 1'b0 : pm_q;
    assign tick_o   = tick_q;
    assign alarm_o  = alarm_q;

endmodule
